// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Definitions shared by the shift-add multiplier and the blocks around it.
//   - state_t           : one-hot accumulator states (S_collect / S_hold)
//   - DP_WIDTH_DEFAULT  : default multiplier operand width
//   - acc_width_min()   : smallest accumulator width that cannot wrap when
//                         summing 'len' products of 'dp_w'-bit operands
// -----------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    S_collect = 2'b01,
    S_hold    = 2'b10
  } state_t;

  localparam int DP_WIDTH_DEFAULT = 5;

  function automatic int acc_width_min(input int dp_w, input int len);
    return 2 * dp_w + $clog2(len);
  endfunction

endpackage

// File: rtl/ready_rise_detect.sv
// -----------------------------------------------------------------------------
// ready_rise_detect
// Registered rising-edge detector on the multiplier Ready line. The history
// register resets to 1 so that a Ready line that is already high out of reset
// (an idle multiplier) does not look like a completed multiplication.
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous active-high reset
//   mul_ready in   multiplier Ready
//   evt       out  one-cycle pulse in the cycle Ready goes 0 -> 1
// -----------------------------------------------------------------------------
module ready_rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic mul_ready,
  output logic evt
);

  logic r_rdy_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdy_d <= 1'b1;
    end else begin
      r_rdy_d <= mul_ready;
    end
  end

  assign evt = mul_ready & ~r_rdy_d;

endmodule

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
// Captures the multiplier Product on every Ready rise and sums acc_len
// consecutive products into a dot-product result, which is then held until
// the next stage acknowledges it. Products completing while a result is held
// are discarded and raise the sticky 'dropped' flag.
//
// Output handshake: out_valid is high while a result is held in acc_out. The
// result is consumed at a rising edge where out_ack is high; from that edge
// out_valid and acc_out are 0. out_ack while out_valid is low is ignored.
//
// Ports:
//   clock, reset  in   clock and synchronous active-high reset
//   mul_ready     in   multiplier Ready (high while idle)
//   mul_product   in   multiplier Product, sampled in the event cycle
//   clear         in   abort the current accumulation (beats ack/event)
//   out_ack       in   downstream accepts the held result
//   acc_out       out  running sum; final sum while out_valid is high
//   out_valid     out  result held
//   acc_count     out  products accumulated so far
//   dropped       out  sticky: a product arrived during hold
//   dbg_state     out  current FSM state encoding
// -----------------------------------------------------------------------------
module product_accumulator
  import mult_pkg::*;
#(
  parameter int dp_width  = DP_WIDTH_DEFAULT,
  parameter int acc_len   = 4,
  parameter int cnt_width = 3,
  parameter int acc_width = 13
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mul_ready,
  input  logic [2*dp_width-1:0] mul_product,
  input  logic                  clear,
  input  logic                  out_ack,
  output logic [acc_width-1:0]  acc_out,
  output logic                  out_valid,
  output logic [cnt_width-1:0]  acc_count,
  output logic                  dropped,
  output logic [1:0]            dbg_state
);

  // Reject parameter sets that could wrap the sum or the counter compare.
  if (acc_width < acc_width_min(dp_width, acc_len)) begin : g_bad_acc_width
    $error("product_accumulator: acc_width too small for dp_width/acc_len");
  end
  if (acc_len < 1 || acc_len > (1 << cnt_width)) begin : g_bad_acc_len
    $error("product_accumulator: acc_len outside 1..2**cnt_width");
  end

  localparam logic [cnt_width-1:0] LAST_CNT = cnt_width'(acc_len - 1);

  logic                 w_evt;
  state_t               r_state;
  state_t               w_state_next;
  logic [acc_width-1:0] r_acc;
  logic [acc_width-1:0] w_acc_next;
  logic [cnt_width-1:0] r_cnt;
  logic [cnt_width-1:0] w_cnt_next;
  logic                 r_dropped;
  logic                 w_dropped_next;

  ready_rise_detect u_ready_rise_detect (
    .clock     (clock),
    .reset     (reset),
    .mul_ready (mul_ready),
    .evt       (w_evt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_collect;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_acc     <= w_acc_next;
      r_cnt     <= w_cnt_next;
      r_dropped <= w_dropped_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_acc_next     = r_acc;
    w_cnt_next     = r_cnt;
    w_dropped_next = r_dropped;

    if (clear) begin
      // A product completing in the clear cycle is discarded silently.
      w_state_next   = S_collect;
      w_acc_next     = '0;
      w_cnt_next     = '0;
      w_dropped_next = 1'b0;
    end else begin
      unique case (r_state)
        S_collect: begin
          if (w_evt) begin
            w_acc_next = r_acc + acc_width'(mul_product);
            w_cnt_next = r_cnt + cnt_width'(1);
            if (r_cnt == LAST_CNT) begin
              w_state_next = S_hold;
            end
          end
        end
        S_hold: begin
          // Result is frozen; any product now has nowhere to go.
          if (w_evt) begin
            w_dropped_next = 1'b1;
          end
          if (out_ack) begin
            w_state_next = S_collect;
            w_acc_next   = '0;
            w_cnt_next   = '0;
          end
        end
        default: begin
          w_state_next = S_collect;
          w_acc_next   = '0;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  assign acc_out   = r_acc;
  assign acc_count = r_cnt;
  assign dropped   = r_dropped;
  assign out_valid = (r_state == S_hold);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  localparam int DPW     = 5;
  localparam int ACC_LEN = 4;
  localparam int CNTW    = 3;
  localparam int ACCW    = 13;

  logic            clock = 1'b0;
  logic            reset;
  logic            mul_ready;
  logic [2*DPW-1:0] mul_product;
  logic            clear;
  logic            out_ack;
  logic [ACCW-1:0] acc_out;
  logic            out_valid;
  logic [CNTW-1:0] acc_count;
  logic            dropped;
  logic [1:0]      dbg_state;

  product_accumulator #(
    .dp_width  (DPW),
    .acc_len   (ACC_LEN),
    .cnt_width (CNTW),
    .acc_width (ACCW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mul_ready   (mul_ready),
    .mul_product (mul_product),
    .clear       (clear),
    .out_ack     (out_ack),
    .acc_out     (acc_out),
    .out_valid   (out_valid),
    .acc_count   (acc_count),
    .dropped     (dropped),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // The current batch is a list of captured products; the result is held
  // exactly when the batch is full.
  int m_q[$];
  bit m_drop = 1'b0;
  bit m_prev = 1'b1;

  function automatic int m_sum();
    int s = 0;
    foreach (m_q[i]) s += m_q[i];
    return s;
  endfunction

  task automatic model_step();
    bit evt;
    if (reset) begin
      m_q.delete();
      m_drop = 1'b0;
      m_prev = 1'b1;
    end else begin
      evt    = mul_ready && !m_prev;
      m_prev = mul_ready;
      if (clear) begin
        m_q.delete();
        m_drop = 1'b0;
      end else if (m_q.size() == ACC_LEN) begin
        if (evt) m_drop = 1'b1;
        if (out_ack) m_q.delete();
      end else if (evt) begin
        m_q.push_back(int'(mul_product));
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit held;
    held = (m_q.size() == ACC_LEN);
    check("model acc_out",   int'(acc_out),   m_sum());
    check("model acc_count", int'(acc_count), m_q.size() % (1 << CNTW));
    check("model out_valid", int'(out_valid), int'(held));
    check("model dropped",   int'(dropped),   int'(m_drop));
    check("model state",     int'(dbg_state), held ? 2 : 1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit r, input int p, input bit clr, input bit ack);
    mul_ready   = r;
    mul_product = p[2*DPW-1:0];
    clear       = clr;
    out_ack     = ack;
    @(posedge clock);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic pulse_product(input int p);
    cyc(1'b0, int'($urandom_range(0, 1023)), 1'b0, 1'b0);
    cyc(1'b1, p, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit r;
    int p;
    bit ack;
    int e_acc;
    int e_cnt;
    bit e_valid;
  } vec_t;

  vec_t tbl[9];

  initial begin
    reset       = 1'b1;
    mul_ready   = 1'b0;
    mul_product = '0;
    clear       = 1'b0;
    out_ack     = 1'b0;

    // Normal dot product 15, 961, 0, 63 -> 1039, then ack.
    tbl[0] = '{1'b0, 0,   1'b0, 0,    0, 1'b0};
    tbl[1] = '{1'b1, 15,  1'b0, 15,   1, 1'b0};
    tbl[2] = '{1'b0, 0,   1'b0, 15,   1, 1'b0};
    tbl[3] = '{1'b1, 961, 1'b0, 976,  2, 1'b0};
    tbl[4] = '{1'b0, 0,   1'b0, 976,  2, 1'b0};
    tbl[5] = '{1'b1, 0,   1'b0, 976,  3, 1'b0};
    tbl[6] = '{1'b0, 0,   1'b0, 976,  3, 1'b0};
    tbl[7] = '{1'b1, 63,  1'b0, 1039, 4, 1'b1};
    tbl[8] = '{1'b1, 0,   1'b1, 0,    0, 1'b0};

    // Reset state; Ready high straight out of reset is not an event.
    do_reset();
    check("reset acc_out",   int'(acc_out),   0);
    check("reset acc_count", int'(acc_count), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset dropped",   int'(dropped),   0);
    check("reset state",     int'(dbg_state), 1);
    cyc(1'b1, 77, 1'b0, 1'b0);
    check("no event after reset", int'(acc_count), 0);

    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].r, tbl[i].p, 1'b0, tbl[i].ack);
      check($sformatf("tbl[%0d] acc_out", i),   int'(acc_out),   tbl[i].e_acc);
      check($sformatf("tbl[%0d] acc_count", i), int'(acc_count), tbl[i].e_cnt);
      check($sformatf("tbl[%0d] out_valid", i), int'(out_valid), int'(tbl[i].e_valid));
    end

    // Maximum values: 4 x 961 = 3844, no wrap.
    for (int i = 0; i < 4; i++) pulse_product(961);
    check("max acc_out",   int'(acc_out),   3844);
    check("max out_valid", int'(out_valid), 1);
    cyc(1'b1, 0, 1'b0, 1'b1);
    check("max ack acc_out", int'(acc_out), 0);

    // Drop during hold, then event coincident with ack.
    pulse_product(15);
    pulse_product(961);
    pulse_product(0);
    pulse_product(63);
    check("drop held acc", int'(acc_out), 1039);
    pulse_product(500);
    check("drop flag",      int'(dropped),   1);
    check("drop acc frozen", int'(acc_out),  1039);
    check("drop cnt frozen", int'(acc_count), 4);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 7, 1'b0, 1'b1);
    check("ack+evt acc_count", int'(acc_count), 0);
    check("ack+evt acc_out",   int'(acc_out),   0);
    check("ack+evt dropped",   int'(dropped),   1);
    check("ack+evt out_valid", int'(out_valid), 0);

    // Clear mid-run, coincident with a third event.
    pulse_product(15);
    pulse_product(63);
    check("pre-clear acc", int'(acc_out), 78);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 100, 1'b1, 1'b0);
    check("clear acc_out",   int'(acc_out),   0);
    check("clear acc_count", int'(acc_count), 0);
    check("clear dropped",   int'(dropped),   0);
    pulse_product(5);
    pulse_product(6);
    pulse_product(7);
    pulse_product(8);
    check("post-clear result", int'(acc_out),   26);
    check("post-clear valid",  int'(out_valid), 1);
    cyc(1'b1, 0, 1'b0, 1'b1);

    // Reset and idle: Ready held high for 50 cycles, then reset mid-run.
    do_reset();
    for (int i = 0; i < 50; i++) cyc(1'b1, int'($urandom_range(0, 1023)), 1'b0, 1'b0);
    check("idle acc_count", int'(acc_count), 0);
    check("idle acc_out",   int'(acc_out),   0);
    pulse_product(15);
    pulse_product(63);
    reset = 1'b1;
    cyc(1'b0, 0, 1'b0, 1'b0);
    reset = 1'b0;
    check("midrun reset acc_out",   int'(acc_out),   0);
    check("midrun reset acc_count", int'(acc_count), 0);
    check("midrun reset out_valid", int'(out_valid), 0);
    check("midrun reset dropped",   int'(dropped),   0);
    cyc(1'b1, 9, 1'b0, 1'b0);
    check("rdy_d high after reset", int'(acc_count), 0);
    pulse_product(9);
    check("first event after reset", int'(acc_out), 9);
    cyc(1'b0, 0, 1'b1, 1'b0);

    // Minimum spacing: Ready toggled every cycle with products 1..4.
    for (int i = 1; i <= 4; i++) pulse_product(i);
    check("spacing acc_out",   int'(acc_out),   10);
    check("spacing out_valid", int'(out_valid), 1);
    cyc(1'b1, 0, 1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 255) == 0);
      cyc(1'(($urandom_range(0, 1))),
          int'($urandom_range(0, 1023)),
          ($urandom_range(0, 63) == 0),
          ($urandom_range(0, 3) == 0));
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
